// File: rtl/fetch_types.sv
// Shared fetch-stage types and constants.
package fetch_types;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD,
    FAULT
  } fetch_state_t;

  localparam logic [63:0] INSTR_BYTES = 64'd4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  function automatic logic is_aligned(input logic [1:0] lsbs);
    return lsbs == 2'b00;
  endfunction

endpackage

// File: rtl/reg_ld.sv
// Loadable register with synchronous active-high reset.
module reg_ld #(
  parameter int unsigned       WIDTH     = 64,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= RESET_VAL;
    else if (ld) q <= d;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one read in flight, held result with ready handshake,
// redirect/kill handling and misaligned-target fault state.
module fetch_unit
  import fetch_types::*;
#(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        mem_rd,
  output logic [63:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [63:0] pc,
  output logic [63:0] pc_plus4,
  output logic        misaligned_fault
);

  fetch_state_t state, state_nxt;
  logic [63:0]  fetch_pc, fetch_pc_d;
  logic         fetch_pc_ld;
  logic [2:0]   cnt, cnt_nxt;
  logic         kill, kill_nxt;
  logic [63:0]  kill_pc, kill_pc_nxt;
  logic         capture;

  reg_ld #(
    .WIDTH     (64),
    .RESET_VAL (RESET_PC)
  ) u_fetch_pc (
    .clk   (clk),
    .reset (reset),
    .ld    (fetch_pc_ld),
    .d     (fetch_pc_d),
    .q     (fetch_pc)
  );

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    kill_nxt    = kill;
    kill_pc_nxt = kill_pc;
    fetch_pc_ld = 1'b0;
    fetch_pc_d  = fetch_pc;
    capture     = 1'b0;
    unique case (state)
      IDLE: begin
        if (redirect_valid) begin
          if (is_aligned(redirect_pc[1:0])) begin
            fetch_pc_ld = 1'b1;
            fetch_pc_d  = redirect_pc;
          end else begin
            state_nxt = FAULT;
          end
        end else if (fetch_req) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        cnt_nxt   = 3'(MEM_LATENCY);
        state_nxt = WAIT;
        if (redirect_valid) begin
          kill_nxt    = 1'b1;
          kill_pc_nxt = redirect_pc;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 3'd1;
        if (redirect_valid) begin
          kill_nxt    = 1'b1;
          kill_pc_nxt = redirect_pc;
        end
        // a redirect arriving in the last wait cycle still kills this read
        if (cnt == 3'd1) begin
          if (kill_nxt) begin
            kill_nxt = 1'b0;
            if (is_aligned(kill_pc_nxt[1:0])) begin
              fetch_pc_ld = 1'b1;
              fetch_pc_d  = kill_pc_nxt;
              state_nxt   = IDLE;
            end else begin
              state_nxt = FAULT;
            end
          end else begin
            capture   = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          if (is_aligned(redirect_pc[1:0])) begin
            fetch_pc_ld = 1'b1;
            fetch_pc_d  = redirect_pc;
            state_nxt   = IDLE;
          end else begin
            state_nxt = FAULT;
          end
        end else if (instr_ready) begin
          fetch_pc_ld = 1'b1;
          fetch_pc_d  = fetch_pc + INSTR_BYTES;
          state_nxt   = IDLE;
        end
      end
      FAULT: begin
        if (redirect_valid && is_aligned(redirect_pc[1:0])) begin
          fetch_pc_ld = 1'b1;
          fetch_pc_d  = redirect_pc;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      kill    <= 1'b0;
      kill_pc <= '0;
      instr   <= NOP_INSTR;
      pc      <= RESET_PC;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      kill    <= kill_nxt;
      kill_pc <= kill_pc_nxt;
      if (capture) begin
        instr <= mem_rdata;
        pc    <= fetch_pc;
      end
    end
  end

  assign mem_rd           = (state == ISSUE);
  assign mem_addr         = fetch_pc;
  assign instr_valid      = (state == HOLD);
  assign misaligned_fault = (state == FAULT);
  assign pc_plus4         = pc + INSTR_BYTES;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (latency 1 and 3) share stimulus; directed
// scenarios plus a randomized run against a behavioural fetch model.
module tb_fetch_unit;

  localparam int          LAT0 = 1;
  localparam int          LAT1 = 3;
  localparam logic [63:0] RPC0 = 64'h0;
  localparam logic [63:0] RPC1 = 64'h1000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, fetch_req, redirect_valid, instr_ready;
  logic [63:0] redirect_pc;
  logic [31:0] mem_rdata [2];
  logic        mem_rd [2];
  logic [63:0] mem_addr [2];
  logic [31:0] instr [2];
  logic        instr_valid [2];
  logic [63:0] pc [2];
  logic [63:0] pc_plus4 [2];
  logic        misaligned_fault [2];

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC0), .MEM_LATENCY(LAT0)) u_l1 (
    .clk(clk), .reset(reset), .fetch_req(fetch_req),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_rd(mem_rd[0]), .mem_addr(mem_addr[0]), .mem_rdata(mem_rdata[0]),
    .instr(instr[0]), .instr_valid(instr_valid[0]), .instr_ready(instr_ready),
    .pc(pc[0]), .pc_plus4(pc_plus4[0]), .misaligned_fault(misaligned_fault[0])
  );

  fetch_unit #(.RESET_PC(RPC1), .MEM_LATENCY(LAT1)) u_l3 (
    .clk(clk), .reset(reset), .fetch_req(fetch_req),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_rd(mem_rd[1]), .mem_addr(mem_addr[1]), .mem_rdata(mem_rdata[1]),
    .instr(instr[1]), .instr_valid(instr_valid[1]), .instr_ready(instr_ready),
    .pc(pc[1]), .pc_plus4(pc_plus4[1]), .misaligned_fault(misaligned_fault[1])
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int          lat [2];
  logic [63:0] rstpc [2];

  // behavioural model: next fetch address, fault mode, and timestamps of the read in flight
  logic [63:0] m_addr [2];
  bit          m_fault [2], m_hold [2], m_issue [2], m_busy [2], m_kill [2];
  int          m_due [2];
  logic [63:0] m_ktgt [2];

  typedef struct {
    int          k;
    int          due;
    logic [63:0] a;
  } rd_t;
  rd_t mq [$];

  function automatic logic [31:0] word(input logic [63:0] a);
    logic [31:0] w;
    case (a)
      64'h0:   w = 32'h00A0_0093;
      64'h4:   w = 32'h0020_8113;
      64'h8:   w = 32'h0020_81B3;
      default: w = (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0000;
    endcase
    return w;
  endfunction

  function automatic bit aligned(input logic [63:0] a);
    return a[1:0] == 2'b00;
  endfunction

  task automatic step(input bit rst, input bit fr, input bit rv,
                      input logic [63:0] rp, input bit rdy);
    rd_t e;
    for (int k = 0; k < 2; k++)
      if (mem_rd[k] === 1'b1) begin
        e.k = k; e.due = cyc + lat[k]; e.a = mem_addr[k];
        mq.push_back(e);
      end
    reset = rst; fetch_req = fr; redirect_valid = rv; redirect_pc = rp; instr_ready = rdy;
    for (int k = 0; k < 2; k++) mem_rdata[k] = $urandom;
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].due == cyc) mem_rdata[mq[i].k] = word(mq[i].a);
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].due <= cyc) mq.delete(i);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_addr[k] = rstpc[k]; m_fault[k] = 0; m_hold[k] = 0;
        m_issue[k] = 0; m_busy[k] = 0; m_kill[k] = 0;
      end else if (m_issue[k]) begin
        m_issue[k] = 0; m_busy[k] = 1; m_due[k] = cyc + lat[k];
        if (rv) begin m_kill[k] = 1; m_ktgt[k] = rp; end
      end else if (m_busy[k]) begin
        if (rv) begin m_kill[k] = 1; m_ktgt[k] = rp; end
        if (cyc == m_due[k]) begin
          m_busy[k] = 0;
          if (m_kill[k]) begin
            m_kill[k] = 0;
            if (aligned(m_ktgt[k])) m_addr[k] = m_ktgt[k];
            else m_fault[k] = 1;
          end else m_hold[k] = 1;
        end
      end else if (m_hold[k]) begin
        if (rv) begin
          m_hold[k] = 0;
          if (aligned(rp)) m_addr[k] = rp; else m_fault[k] = 1;
        end else if (rdy) begin
          m_hold[k] = 0; m_addr[k] = m_addr[k] + 64'd4;
        end
      end else if (m_fault[k]) begin
        if (rv && aligned(rp)) begin m_fault[k] = 0; m_addr[k] = rp; end
      end else begin
        if (rv) begin
          if (aligned(rp)) m_addr[k] = rp; else m_fault[k] = 1;
        end else if (fr) m_issue[k] = 1;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 64'h0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 64'h0, 0);
    idle();
  endtask

  task automatic test_reset();
    step(1, 1, 1, 64'h80, 1);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (instr_valid[k] !== 1'b0 || mem_rd[k] !== 1'b0 || misaligned_fault[k] !== 1'b0) begin
        bad++; $display("FAIL reset_flags[%0d] got v=%b rd=%b f=%b want 0/0/0",
                        k, instr_valid[k], mem_rd[k], misaligned_fault[k]);
      end
      total++;
      if (pc[k] !== rstpc[k] || instr[k] !== NOP) begin
        bad++; $display("FAIL reset_pc_instr[%0d] got pc=%h instr=%h want pc=%h instr=%h",
                        k, pc[k], instr[k], rstpc[k], NOP);
      end
      total++;
      if (mem_addr[k] !== rstpc[k]) begin
        bad++; $display("FAIL reset_addr[%0d] got %h want %h", k, mem_addr[k], rstpc[k]);
      end
    end
    idle();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (mem_rd[k] !== 1'b0 || mem_addr[k] !== rstpc[k]) begin
        bad++; $display("FAIL reset_priority[%0d] got rd=%b addr=%h want 0 %h",
                        k, mem_rd[k], mem_addr[k], rstpc[k]);
      end
    end
  endtask

  task automatic test_first_fetch();
    do_reset();
    step(0, 1, 0, 64'h0, 0);
    total++;
    if (mem_rd[0] !== 1'b1 || mem_addr[0] !== 64'h0 || mem_rd[1] !== 1'b1 || mem_addr[1] !== RPC1) begin
      bad++; $display("FAIL first_issue got rd=%b/%b addr=%h/%h want 1/1 0/%h",
                      mem_rd[0], mem_rd[1], mem_addr[0], mem_addr[1], RPC1);
    end
    idle();
    total++;
    if (instr_valid[0] !== 1'b0 || mem_rd[0] !== 1'b0) begin
      bad++; $display("FAIL first_wait got v=%b rd=%b want 0 0", instr_valid[0], mem_rd[0]);
    end
    idle();
    total++;
    if (instr_valid[0] !== 1'b1 || pc[0] !== 64'h0 || pc_plus4[0] !== 64'h4 || instr[0] !== 32'h00A0_0093) begin
      bad++; $display("FAIL first_hold got v=%b pc=%h p4=%h instr=%h want 1 0 4 00a00093",
                      instr_valid[0], pc[0], pc_plus4[0], instr[0]);
    end
    total++;
    if (instr_valid[1] !== 1'b0) begin
      bad++; $display("FAIL first_l3_early got v=%b want 0", instr_valid[1]);
    end
    idle();
    idle();
    total++;
    if (instr_valid[0] !== 1'b1 || pc[0] !== 64'h0 || instr_valid[1] !== 1'b1 ||
        pc[1] !== RPC1 || instr[1] !== word(RPC1)) begin
      bad++; $display("FAIL first_l3_hold got v=%b/%b pc=%h/%h instr1=%h want 1/1 0/%h %h",
                      instr_valid[0], instr_valid[1], pc[0], pc[1], instr[1], RPC1, word(RPC1));
    end
    step(0, 0, 0, 64'h0, 1);
    total++;
    if (instr_valid[0] !== 1'b0 || instr_valid[1] !== 1'b0 ||
        mem_addr[0] !== 64'h4 || mem_addr[1] !== RPC1 + 64'h4) begin
      bad++; $display("FAIL first_accept got v=%b/%b addr=%h/%h want 0/0 4/%h",
                      instr_valid[0], instr_valid[1], mem_addr[0], mem_addr[1], RPC1 + 64'h4);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h00A0_0093; exp_w[1] = 32'h0020_8113; exp_w[2] = 32'h0020_81B3;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 64'h0, 0);
      idle();
      idle();
      total++;
      if (instr_valid[0] !== 1'b1 || instr[0] !== exp_w[i] || pc[0] !== 64'(4 * i)) begin
        bad++; $display("FAIL b2b_%0d got v=%b instr=%h pc=%h want 1 %h %h",
                        i, instr_valid[0], instr[0], pc[0], exp_w[i], 64'(4 * i));
      end
      step(0, 0, 0, 64'h0, 1);
      total++;
      if (instr_valid[0] !== 1'b0) begin
        bad++; $display("FAIL b2b_drop_%0d got v=%b want 0", i, instr_valid[0]);
      end
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    step(0, 1, 0, 64'h0, 0);
    idle();
    step(0, 0, 1, 64'h40, 0);
    total++;
    if (mem_addr[1] !== RPC1) begin
      bad++; $display("FAIL kill_addr_stable got %h want %h", mem_addr[1], RPC1);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (instr_valid[1] !== 1'b0) begin
        bad++; $display("FAIL kill_no_valid_%0d got %b want 0", i, instr_valid[1]);
      end
      idle();
    end
    total++;
    if (mem_addr[1] !== 64'h40) begin
      bad++; $display("FAIL kill_target got %h want 40", mem_addr[1]);
    end
    step(0, 1, 0, 64'h0, 0);
    total++;
    if (mem_rd[1] !== 1'b1 || mem_addr[1] !== 64'h40) begin
      bad++; $display("FAIL kill_refetch got rd=%b addr=%h want 1 40", mem_rd[1], mem_addr[1]);
    end
    for (int i = 0; i < 4; i++) idle();
    total++;
    if (instr_valid[1] !== 1'b1 || pc[1] !== 64'h40 || instr[1] !== word(64'h40)) begin
      bad++; $display("FAIL kill_refetch_hold got v=%b pc=%h instr=%h want 1 40 %h",
                      instr_valid[1], pc[1], instr[1], word(64'h40));
    end
  endtask

  task automatic test_redirect_hold();
    do_reset();
    step(0, 1, 0, 64'h0, 0);
    idle();
    idle();
    step(0, 0, 1, 64'h100, 1);
    total++;
    if (instr_valid[0] !== 1'b0 || mem_addr[0] !== 64'h100) begin
      bad++; $display("FAIL hold_redirect got v=%b addr=%h want 0 100", instr_valid[0], mem_addr[0]);
    end
    step(0, 1, 0, 64'h0, 0);
    idle();
    idle();
    total++;
    if (instr_valid[0] !== 1'b1 || pc[0] !== 64'h100 || instr[0] !== word(64'h100)) begin
      bad++; $display("FAIL hold_redirect_fetch got v=%b pc=%h instr=%h want 1 100 %h",
                      instr_valid[0], pc[0], instr[0], word(64'h100));
    end
  endtask

  task automatic test_fault();
    do_reset();
    step(0, 0, 1, 64'h102, 0);
    step(0, 1, 0, 64'h0, 0);
    step(0, 1, 0, 64'h0, 0);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (misaligned_fault[k] !== 1'b1 || mem_rd[k] !== 1'b0) begin
        bad++; $display("FAIL fault_set[%0d] got f=%b rd=%b want 1 0", k, misaligned_fault[k], mem_rd[k]);
      end
    end
    step(0, 0, 1, 64'h200, 0);
    step(0, 1, 0, 64'h0, 0);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (misaligned_fault[k] !== 1'b0 || mem_rd[k] !== 1'b1 || mem_addr[k] !== 64'h200) begin
        bad++; $display("FAIL fault_clear[%0d] got f=%b rd=%b addr=%h want 0 1 200",
                        k, misaligned_fault[k], mem_rd[k], mem_addr[k]);
      end
    end
    do_reset();
    step(0, 1, 0, 64'h0, 0);
    idle();
    step(0, 0, 1, 64'h3, 0);
    total++;
    if (misaligned_fault[1] !== 1'b0) begin
      bad++; $display("FAIL fault_drain got %b want 0", misaligned_fault[1]);
    end
    idle();
    idle();
    total++;
    if (misaligned_fault[1] !== 1'b1 || instr_valid[1] !== 1'b0) begin
      bad++; $display("FAIL fault_after_drain got f=%b v=%b want 1 0", misaligned_fault[1], instr_valid[1]);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    step(0, 1, 0, 64'h0, 0);
    idle();
    idle();
    total++;
    if (pc[0] !== 64'hFFFF_FFFF_FFFF_FFFC || pc_plus4[0] !== 64'h0) begin
      bad++; $display("FAIL wrap_pc got pc=%h p4=%h want fffffffffffffffc 0", pc[0], pc_plus4[0]);
    end
    step(0, 0, 0, 64'h0, 1);
    total++;
    if (mem_addr[0] !== 64'h0) begin
      bad++; $display("FAIL wrap_next got %h want 0", mem_addr[0]);
    end
  endtask

  task automatic test_reset_wait();
    do_reset();
    step(0, 1, 0, 64'h0, 0);
    idle();
    step(1, 0, 0, 64'h0, 0);
    total++;
    if (instr_valid[1] !== 1'b0 || pc[1] !== RPC1 || instr[1] !== NOP || mem_addr[1] !== RPC1) begin
      bad++; $display("FAIL rst_wait got v=%b pc=%h instr=%h addr=%h want 0 %h %h %h",
                      instr_valid[1], pc[1], instr[1], mem_addr[1], RPC1, NOP, RPC1);
    end
    for (int i = 0; i < 5; i++) begin
      idle();
      total++;
      if (instr_valid[1] !== 1'b0 || instr[1] !== NOP) begin
        bad++; $display("FAIL rst_stale_%0d got v=%b instr=%h want 0 %h", i, instr_valid[1], instr[1], NOP);
      end
    end
  endtask

  task automatic test_random();
    bit          rst, fr, rv, rdy;
    logic [63:0] rp;
    int unsigned sel;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom % 64) == 0;
      fr  = $urandom % 2;
      rv  = ($urandom % 8) == 0;
      rdy = $urandom % 2;
      sel = $urandom % 8;
      rp  = {$urandom, $urandom};
      if (sel != 0) rp[1:0] = 2'b00;
      if (sel == 1) rp = 64'hFFFF_FFFF_FFFF_FFFC;
      else if (sel > 3) rp[63:12] = '0;
      step(rst, fr, rv, rp, rdy);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (mem_rd[k] !== m_issue[k] || mem_addr[k] !== m_addr[k]) begin
          bad++; $display("FAIL rnd_read[%0d] cyc=%0d got rd=%b addr=%h want %b %h",
                          k, cyc, mem_rd[k], mem_addr[k], m_issue[k], m_addr[k]);
        end
        total++;
        if (instr_valid[k] !== m_hold[k] || misaligned_fault[k] !== m_fault[k]) begin
          bad++; $display("FAIL rnd_status[%0d] cyc=%0d got v=%b f=%b want %b %b",
                          k, cyc, instr_valid[k], misaligned_fault[k], m_hold[k], m_fault[k]);
        end
        if (m_hold[k]) begin
          total++;
          if (instr[k] !== word(m_addr[k]) || pc[k] !== m_addr[k] || pc_plus4[k] !== m_addr[k] + 64'd4) begin
            bad++; $display("FAIL rnd_hold[%0d] cyc=%0d got instr=%h pc=%h p4=%h want %h %h %h",
                            k, cyc, instr[k], pc[k], pc_plus4[k], word(m_addr[k]), m_addr[k], m_addr[k] + 64'd4);
          end
        end
      end
    end
  endtask

  initial begin
    lat[0] = LAT0; lat[1] = LAT1;
    rstpc[0] = RPC0; rstpc[1] = RPC1;
    reset = 1'b1; fetch_req = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    mem_rdata[0] = '0; mem_rdata[1] = '0;
    @(negedge clk);
    test_reset();
    test_first_fetch();
    test_back_to_back();
    test_redirect_wait();
    test_redirect_hold();
    test_fault();
    test_wrap();
    test_reset_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, the first fetch address after reset.
REQ-002 SHALL have parameter MEM_LATENCY, default 1, the instruction-memory read latency in cycles; legal range 1..4.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port fetch_req, input, 1, control requests the next instruction.
REQ-006 SHALL have port redirect_valid, input, 1, branch/jump redirect strobe.
REQ-007 SHALL have port redirect_pc, input, 64, redirect target byte address.
REQ-008 SHALL have port mem_rd, output, 1, one-cycle read strobe to instruction memory.
REQ-009 SHALL have port mem_addr, output, 64, read byte address.
REQ-010 SHALL have port mem_rdata, input, 32, read data, valid MEM_LATENCY cycles after mem_rd.
REQ-011 SHALL have port instr, output, 32, held instruction word.
REQ-012 SHALL have port instr_valid, output, 1, instr and pc are valid.
REQ-013 SHALL have port instr_ready, input, 1, the consumer accepts instr this cycle.
REQ-014 SHALL have port pc, output, 64, address of instr.
REQ-015 SHALL have port pc_plus4, output, 64, pc + 4, combinational.
REQ-016 SHALL have port misaligned_fault, output, 1, the redirect target is not word-aligned.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT, HOLD, FAULT, with internal register fetch_pc.
REQ-018 IDLE: on fetch_req=1 with redirect_valid=0, SHALL go to ISSUE; otherwise remain in IDLE.
REQ-019 ISSUE: SHALL drive mem_rd=1 and mem_addr=fetch_pc for exactly one cycle, load the wait counter with MEM_LATENCY, and go to WAIT.
REQ-020 WAIT: SHALL decrement the counter each cycle; in the cycle the counter reaches 1, SHALL capture mem_rdata into instr and fetch_pc into pc, then go to HOLD.
REQ-021 Latency: fetch_req sampled in IDLE at cycle N SHALL give instr_valid=1 at cycle N+2+MEM_LATENCY.
REQ-022 HOLD: SHALL keep instr_valid=1 and instr/pc stable until instr_ready=1, then set fetch_pc<=fetch_pc+4 and go to IDLE; instr_valid SHALL drop the following cycle.
REQ-023 Outside HOLD: instr_valid SHALL be 0, mem_rd SHALL be 0 (except in ISSUE), and instr_ready SHALL be ignored.
REQ-024 Redirect in IDLE or HOLD: SHALL load fetch_pc<=redirect_pc and go to IDLE; in HOLD the held instruction is discarded even if instr_ready=1 in the same cycle.
REQ-025 Redirect in ISSUE or WAIT: SHALL latch redirect_pc and set a kill flag; the outstanding read SHALL complete, its data SHALL be dropped without asserting instr_valid, fetch_pc SHALL take the latched target, and the FSM SHALL go to IDLE; a later redirect overwrites the latched target.
REQ-026 Redirect with redirect_pc[1:0]!=0: SHALL go to FAULT (after any outstanding read drains) with misaligned_fault=1 and mem_rd=0.
REQ-027 FAULT: SHALL ignore fetch_req; leave FAULT only on an aligned redirect, loading fetch_pc and going to IDLE.
REQ-028 fetch_pc+4 SHALL wrap modulo 2^64 with no flag.
REQ-029 mem_addr SHALL equal fetch_pc in every state, so it is stable while a read is outstanding.

Reset
REQ-030 reset=1 SHALL, at the next clock edge, set state=IDLE, fetch_pc=RESET_PC, pc=RESET_PC, instr=32'h0000_0013 (NOP), instr_valid=0, mem_rd=0, misaligned_fault=0, kill=0, and counter=0.
REQ-031 Reset mid-read SHALL abandon the outstanding read; late mem_rdata SHALL never be captured.
REQ-032 reset SHALL take priority over fetch_req and redirect_valid in the same cycle.

Structure
REQ-033 Enum fetch_state_t, constant INSTR_BYTES=4 and constant NOP_INSTR SHALL live in a new shared package fetch_types, alongside opcodes and operations.
REQ-034 The fetch_pc register SHALL be an instance of the existing 64-bit loadable register reg_ld; the FSM, counter and instr capture SHALL be local.

Verification
REQ-035 Reset, then fetch_req pulse at cycle 2 with MEM_LATENCY=1 -> mem_rd=1 with mem_addr=0 at cycle 3; instr_valid=1, pc=0, pc_plus4=4 at cycle 5.
REQ-036 Three back-to-back fetches, with instr_ready asserted the first cycle of each HOLD and memory words 0x00A00093/0x00208113/0x002081B3 -> instr sequence matches, pc=0/4/8.
REQ-037 redirect_pc=0x40 in the first WAIT cycle with MEM_LATENCY=3 -> no instr_valid for that read; next mem_addr=0x40.
REQ-038 In HOLD, redirect_valid=1 with redirect_pc=0x100 and instr_ready=1 in the same cycle -> next fetch at 0x100, not pc+4.
REQ-039 redirect_pc=0x102 -> misaligned_fault=1 and fetch_req ignored; aligned redirect to 0x200 clears the fault and the next fetch uses 0x200.
REQ-040 reset asserted in WAIT -> instr_valid=0, pc=RESET_PC, and stale mem_rdata is not captured.
